// File: rtl/gg_mb_sequencer_if.sv
// Signal bundle between the macroblock sequencer, the frame controller and the
// 4x4 block pipe. The sequencer takes the master side.
interface gg_mb_sequencer_if;
  logic       mb_start;
  logic       hold;
  logic [2:0] cidx;
  logic [3:0] bidx;
  logic       blk_valid;
  logic       blk_last;
  logic       busy;
  logic       mb_done;
  logic       pic_done;
  logic [7:0] mb_x;
  logic [7:0] mb_y;
  logic       abv_out_of_pic;
  logic       left_out_of_pic;

  modport master (
    input  mb_start, hold,
    output cidx, bidx, blk_valid, blk_last, busy, mb_done, pic_done,
           mb_x, mb_y, abv_out_of_pic, left_out_of_pic
  );

  modport slave (
    output mb_start, hold,
    input  cidx, bidx, blk_valid, blk_last, busy, mb_done, pic_done,
           mb_x, mb_y, abv_out_of_pic, left_out_of_pic
  );
endinterface

// File: rtl/gg_mb_sequencer.sv
// Macroblock sequencer: issues the 26 blocks of a 4:2:0 macroblock to gg_process,
// waits for the pipe to drain, then reports completion and advances the position.
module gg_mb_sequencer #(
  parameter int PIPE_LAT  = 8,
  parameter int MB_WIDTH  = 120,
  parameter int MB_HEIGHT = 68
) (
  input logic               clk,
  input logic               reset,
  gg_mb_sequencer_if.master sif
);

  localparam logic [4:0] SEQ_LAST   = 5'd25;
  localparam logic [4:0] DRAIN_INIT = 5'(PIPE_LAT - 1);
  localparam logic [7:0] X_LAST     = 8'(MB_WIDTH - 1);
  localparam logic [7:0] Y_LAST     = 8'(MB_HEIGHT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] seq_q, seq_d;
  logic [4:0] cnt_q, cnt_d;
  logic [2:0] cidx_q, cidx_d;
  logic [3:0] bidx_q, bidx_d;
  logic [7:0] mb_x_q, mb_x_d;
  logic [7:0] mb_y_q, mb_y_d;
  logic       issue;
  logic       last_col;
  logic       last_row;

  // Coding order: 16 luma, DC cb, DC cr, 4 cb AC, 4 cr AC. Both chroma AC runs
  // start at an index that is 2 mod 4, so bidx is the low two bits plus 2.
  function automatic logic [6:0] blk_map(input logic [4:0] s);
    if (s < 5'd16)       blk_map = {3'd0, s[3:0]};
    else if (s == 5'd16) blk_map = {3'd4, 4'd0};
    else if (s == 5'd17) blk_map = {3'd5, 4'd0};
    else if (s < 5'd22)  blk_map = {3'd2, 2'b00, 2'(s[1:0] + 2'd2)};
    else                 blk_map = {3'd3, 2'b00, 2'(s[1:0] + 2'd2)};
  endfunction

  assign last_col = (mb_x_q == X_LAST);
  assign last_row = (mb_y_q == Y_LAST);

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    cnt_d   = cnt_q;
    cidx_d  = cidx_q;
    bidx_d  = bidx_q;
    mb_x_d  = mb_x_q;
    mb_y_d  = mb_y_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sif.mb_start) begin
          state_d          = ST_ISSUE;
          seq_d            = 5'd0;
          {cidx_d, bidx_d} = blk_map(5'd0);
        end
      end
      ST_ISSUE: begin
        if (!sif.hold) begin
          issue = 1'b1;
          if (seq_q == SEQ_LAST) begin
            state_d = ST_DRAIN;
            cnt_d   = DRAIN_INIT;
          end else begin
            seq_d            = seq_q + 5'd1;
            {cidx_d, bidx_d} = blk_map(seq_q + 5'd1);
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == 5'd0) state_d = ST_DONE;
        else               cnt_d   = cnt_q - 5'd1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (last_col) begin
          mb_x_d = 8'd0;
          mb_y_d = last_row ? 8'd0 : mb_y_q + 8'd1;
        end else begin
          mb_x_d = mb_x_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      seq_q   <= 5'd0;
      cnt_q   <= 5'd0;
      cidx_q  <= 3'd0;
      bidx_q  <= 4'd0;
      mb_x_q  <= 8'd0;
      mb_y_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
      cidx_q  <= cidx_d;
      bidx_q  <= bidx_d;
      mb_x_q  <= mb_x_d;
      mb_y_q  <= mb_y_d;
    end
  end

  assign sif.cidx            = cidx_q;
  assign sif.bidx            = bidx_q;
  assign sif.blk_valid       = issue;
  assign sif.blk_last        = issue && (seq_q == SEQ_LAST);
  assign sif.busy            = (state_q != ST_IDLE);
  assign sif.mb_done         = (state_q == ST_DONE);
  assign sif.pic_done        = (state_q == ST_DONE) && last_col && last_row;
  assign sif.mb_x            = mb_x_q;
  assign sif.mb_y            = mb_y_q;
  assign sif.abv_out_of_pic  = (mb_y_q == 8'd0);
  assign sif.left_out_of_pic = (mb_x_q == 8'd0);

endmodule

// File: doc/gg_mb_sequencer.md
# gg_mb_sequencer

Macroblock sequencer for the 4x4 block processing pipe (`gg_process`). It steps the pipe through the fixed 26-block coding order of one 4:2:0 macroblock, driving `cidx`/`bidx` with an issue strobe. It tracks macroblock position in the picture so it can drive the above and left out-of-picture flags. It waits for the pipe to drain and then reports macroblock and picture completion to the frame-level controller.

## Interface
Parameters:
- `PIPE_LAT`, 8: cycles from block issue to that block's results valid at `gg_process` outputs (1..31).
- `MB_WIDTH`, 120: picture width in macroblocks (1..255).
- `MB_HEIGHT`, 68: picture height in macroblocks (1..255).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mb_start`  in  1  request to code next macroblock; sampled only in IDLE.
- `hold`  in  1  stalls issue; the block in `cidx`/`bidx` is held and `blk_valid` is low.
- `cidx`  out  3  component index to pipe (0-luma, 2-cb ac, 3-cr ac, 4-dc cb, 5-dc cr).
- `bidx`  out  4  block index within component.
- `blk_valid`  out  1  block on `cidx`/`bidx` is issued this cycle.
- `blk_last`  out  1  qualifies `blk_valid` for block 25.
- `busy`  out  1  high from start acceptance until `mb_done`, inclusive.
- `mb_done`  out  1  one-cycle pulse; all 26 results of the macroblock have left the pipe.
- `pic_done`  out  1  one-cycle pulse coincident with `mb_done` of the last macroblock.
- `mb_x`  out  8  column of current macroblock.
- `mb_y`  out  8  row of current macroblock.
- `abv_out_of_pic`  out  1  `mb_y == 0`.
- `left_out_of_pic`  out  1  `mb_x == 0`.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- **IDLE:**
  - `busy` = 0.
  - When `mb_start` = 1, go to ISSUE and clear the sequence index `seq` (0..25).
- **ISSUE:**
  - Each cycle with `hold` = 0: `blk_valid` = 1 and `seq` increments.
  - Each cycle with `hold` = 1: `blk_valid` = 0 and `seq` holds.
  - After `seq` = 25 issues, go to DRAIN and load the drain counter with `PIPE_LAT - 1`.
- **Mapping of `seq` to `cidx`/`bidx`:**
  - `seq` 0..15: cidx 0, bidx = `seq`.
  - `seq` 16: cidx 4, bidx 0.
  - `seq` 17: cidx 5, bidx 0.
  - `seq` 18..21: cidx 2, bidx 0..3.
  - `seq` 22..25: cidx 3, bidx 0..3.
  - `cidx`/`bidx` are registered and combinationally consistent with `blk_valid`.
- **DRAIN:**
  - Counter decrements every cycle; `hold` has no effect.
  - At 0, go to DONE.
  - `cidx`/`bidx` keep the last issued values.
- **DONE (one cycle):**
  - `mb_done` = 1.
  - Position update:
    - If `mb_x == MB_WIDTH-1`: `mb_x` goes to 0, and `mb_y` increments (wraps to 0 after `MB_HEIGHT-1`).
    - Otherwise `mb_x` increments.
  - `pic_done` = 1 when `mb_x == MB_WIDTH-1` and `mb_y == MB_HEIGHT-1` before the update.
  - Next state is IDLE.
- **Outputs:**
  - `abv_out_of_pic`/`left_out_of_pic` are decoded from the registered position.
  - They are stable for the whole macroblock and change only on the cycle after DONE.
- **Boundary cases:**
  - `mb_start` in ISSUE/DRAIN/DONE is ignored and not queued.
  - `MB_WIDTH` = 1: every macroblock has `left_out_of_pic` = 1, and `mb_y` advances on every `mb_done`.
  - `hold` asserted on the cycle ISSUE is entered: no issue until it drops.
  - Reset mid-operation aborts the macroblock with no `mb_done`.

## Timing
- Reset values:
  - State IDLE, `seq` 0.
  - `cidx` 0, `bidx` 0.
  - `blk_valid`, `blk_last`, `busy`, `mb_done`, `pic_done` all 0.
  - `mb_x` 0, `mb_y` 0.
  - `abv_out_of_pic` 1, `left_out_of_pic` 1.
- `mb_start` high in cycle T:
  - `busy` and first `blk_valid` (cidx 0, bidx 0) in T+1.
  - Last issue in T+26 with no hold.
  - `mb_done` in T+26+`PIPE_LAT`+1.
- Each hold cycle during ISSUE delays all later events by one cycle.
- Earliest next `mb_start` acceptance: the cycle after `mb_done` (IDLE).
- Back-to-back macroblock period with no hold: 28 + `PIPE_LAT` cycles.

## Test plan
- **Reset-out state:** reset 2 cycles, then idle 5 cycles -> all outputs at reset values; `abv_out_of_pic` = `left_out_of_pic` = 1.
- **Single macroblock, default parameters:** `mb_start` pulse at T -> `blk_valid` high T+1..T+26 with the exact 26-entry cidx/bidx order; `blk_last` only at T+26; `mb_done` at T+35; `mb_x` = 1 and `left_out_of_pic` = 0 at T+36.
- **Hold stall:** `hold` high for 3 cycles at `seq` 10 -> cidx 0/bidx 10 held with `blk_valid` low; `mb_done` at T+38; no block skipped or duplicated.
- **Row/picture wrap:** `MB_WIDTH` 3, `MB_HEIGHT` 2, 6 macroblocks -> (x,y) sequence (0,0)(1,0)(2,0)(0,1)(1,1)(2,1); `abv_out_of_pic` drops at (0,1); `pic_done` only with the 6th `mb_done`; position returns to (0,0).
- **Ignored start:** `mb_start` held high throughout ISSUE and DRAIN -> exactly one macroblock processed per IDLE acceptance; next one starts the cycle after `mb_done`.
- **Mid-operation reset:** reset at `seq` 20 -> next cycle is IDLE, `blk_valid` 0, no `mb_done`, position (0,0).
